// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    localparam int LANE_W      = 8;
    localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/mem_array.sv
// Word-wide RAM with per-lane write enables and combinational read.
module mem_array
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = "",
  parameter int    ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][i*LANE_W +: LANE_W] <=
            wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder: accept, wait LATENCY cycles, answer once.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    mem_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              byte_q, byte_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [31:0]       rd_now;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
        wr_q    <= wr_d;
        byte_q  <= byte_d;
        mis_q   <= mis_d;
        idx_q   <= idx_d;
        lane_q  <= lane_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    byte_d  = req_byte;
                    mis_d   = !req_byte && (req_addr[1:0] != 2'b00);
                    idx_d   = req_addr[ADDR_W+1:2];
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stores commit on the edge that ends RESP; a reset on that edge drops them.
    always_comb begin
        busy       = reset && req_valid && (state_q != RESP);
        resp_valid = (state_q == RESP);
        mem_we     = resp_valid && wr_q && !mis_q && reset;
        mem_be     = byte_q ? (4'b0001 << lane_q) : 4'hF;
        mem_wdata  = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
        rd_now     = '0;
        if (!mis_q && !wr_q) begin
            rd_now = byte_q ? {24'b0, mem_rdata[{lane_q, 3'b000} +: LANE_W]}
                            : mem_rdata;
        end
        rdata_d = resp_valid ? rd_now : rdata_q;
        err_d   = resp_valid ? mis_q : err_q;
        rdata   = rdata_d;
        err     = err_d;
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .be   (mem_be),
        .idx  (idx_q),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

endmodule
